// File: rtl/vtj1_gpio2_pkg.sv
// vtj1_gpio2_pkg -- shared constants for the VTJ-1 second-generation GPIO device.
//   Register addresses (full 8-bit form, as software sees them), the 4-bit
//   decode keys the device actually compares ({adr[7], adr[2:0]}), command
//   codes for the command register and the version byte.
package vtj1_gpio2_pkg;

    localparam logic [7:0] VERSION = 8'h02;

    // Bus addresses
    localparam logic [7:0] ADR_NLED  = 8'h00;
    localparam logic [7:0] ADR_NBTN  = 8'h01;
    localparam logic [7:0] ADR_VER   = 8'h02;
    localparam logic [7:0] ADR_LED   = 8'h80;
    localparam logic [7:0] ADR_BTN   = 8'h81;
    localparam logic [7:0] ADR_CMD   = 8'h82;
    localparam logic [7:0] ADR_PPEND = 8'h83;
    localparam logic [7:0] ADR_PMASK = 8'h84;
    localparam logic [7:0] ADR_RMASK = 8'h85;
    localparam logic [7:0] ADR_RPEND = 8'h86;

    // Decode keys: only adr[7] and adr[2:0] take part in decoding
    typedef enum logic [3:0] {
        REG_NLED  = 4'h0,
        REG_NBTN  = 4'h1,
        REG_VER   = 4'h2,
        REG_LED   = 4'h8,
        REG_BTN   = 4'h9,
        REG_CMD   = 4'hA,
        REG_PPEND = 4'hB,
        REG_PMASK = 4'hC,
        REG_RMASK = 4'hD,
        REG_RPEND = 4'hE
    } reg_e;

    // Command register codes (wrt[4:0])
    typedef enum logic [4:0] {
        CMD_ROM_ON   = 5'd10,
        CMD_BEEP_ON  = 5'd15,
        CMD_ROM_OFF  = 5'd20,
        CMD_BEEP_OFF = 5'd25
    } cmd_e;

    function automatic logic [3:0] reg_key(input logic [7:0] a);
        return {a[7], a[2:0]};
    endfunction

endpackage

// File: rtl/vtj1_gpio2_if.sv
// vtj1_gpio2_if -- standard VTJ-1 register bus.
//   adr    : register address          (master -> slave)
//   adr_d1 : adr delayed one clock     (master -> slave)
//   wrt    : write data                (master -> slave)
//   wen    : write enable              (master -> slave)
//   red    : registered read data      (slave  -> master)
interface vtj1_gpio2_if;
    logic [7:0] adr;
    logic [7:0] adr_d1;
    logic [7:0] wrt;
    logic       wen;
    logic [7:0] red;

    modport master (output adr, output adr_d1, output wrt, output wen, input red);
    modport slave  (input adr, input adr_d1, input wrt, input wen, output red);
endinterface

// File: rtl/vtj1_gpio2_debounce.sv
// vtj1_gpio2_debounce -- single-bit debounce filter.
//   The output follows the input only after the input has differed from the
//   output for 2**DBW consecutive clocks; any return to the output value
//   restarts the count.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset (q and counter cleared)
//   d   : synchronised input
//   q   : filtered output
module vtj1_gpio2_debounce #(
    parameter int DBW = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DBW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= 1'b0;
            cnt <= '0;
        end else if (d == q) begin
            cnt <= '0;
        end else if (cnt == '1) begin
            // 2**DBW-th consecutive differing cycle: accept the new level
            q   <= d;
            cnt <= '0;
        end else begin
            cnt <= cnt + DBW'(1);
        end
    end

endmodule

// File: rtl/vtj1_gpio2.sv
// vtj1_gpio2 -- VTJ-1 second-generation GPIO device.
//   LED register, button inputs with press/release event latching and
//   maskable interrupts, write_rom/beep command strobes.
//   Build option: define VTJ1_GPIO2_DEBOUNCE_EN to insert a per-button
//   debounce filter (vtj1_gpio2_debounce) after the synchroniser.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : register bus (slave side); red is registered, latency 1
//   irqa      : any enabled press event pending (registered)
//   irqb      : any enabled release event pending (registered)
//   raw_btns  : asynchronous active-high button inputs
//   leds      : registered LED drive
//   write_rom : program memory writeable
//   beep      : beep enable
//   dimctl    : high forces leds to 0
module vtj1_gpio2
    import vtj1_gpio2_pkg::*;
#(
    parameter int NBTN = 4,
    parameter int NLED = 5,
    parameter int DBW  = 16
) (
    input  logic            clk,
    input  logic            rst,
    vtj1_gpio2_if.slave     bus,
    output logic            irqa,
    output logic            irqb,
    input  logic [NBTN-1:0] raw_btns,
    output logic [NLED-1:0] leds,
    output logic            write_rom,
    output logic            beep,
    input  logic            dimctl
);

    logic [3:0]      key;
    logic [NBTN-1:0] sync1, sync2, btns, prev;
    logic [NBTN-1:0] press_ev, rel_ev;
    logic [NBTN-1:0] ppend, rpend, pmask, rmask;
    logic [NBTN-1:0] pclr, rclr;
    logic [NLED-1:0] ledreg;
    logic [7:0]      rdata;

    // Bus fields that play no part in decoding
    logic unused_bus;
    assign unused_bus = ^{bus.adr_d1, bus.adr[6:3]};

    assign key = reg_key(bus.adr);

    // ---------------- button path ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_btns;
            sync2 <= sync1;
        end
    end

`ifdef VTJ1_GPIO2_DEBOUNCE_EN
    for (genvar i = 0; i < NBTN; i++) begin : g_db
        vtj1_gpio2_debounce #(.DBW(DBW)) u_db (
            .clk (clk),
            .rst (rst),
            .d   (sync2[i]),
            .q   (btns[i])
        );
    end
`else
    assign btns = sync2;
    // DBW only sizes the filter counters, which this build omits
    logic [DBW-1:0] unused_dbw;
    assign unused_dbw = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= '0;
        else     prev <= btns;
    end

    assign press_ev = btns & ~prev;
    assign rel_ev   = ~btns & prev;

    // W1C clear masks for this cycle
    always_comb begin
        pclr = '0;
        rclr = '0;
        if (bus.wen && key == REG_PPEND) pclr = bus.wrt[NBTN-1:0];
        if (bus.wen && key == REG_RPEND) rclr = bus.wrt[NBTN-1:0];
    end

    // ---------------- register writes ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ledreg    <= '0;
            pmask     <= '0;
            rmask     <= '0;
            ppend     <= '0;
            rpend     <= '0;
            write_rom <= 1'b0;
            beep      <= 1'b0;
        end else begin
            // A new event wins over a W1C clear of the same bit
            ppend <= (ppend & ~pclr) | press_ev;
            rpend <= (rpend & ~rclr) | rel_ev;
            if (bus.wen) begin
                case (key)
                    REG_LED:   ledreg <= bus.wrt[NLED-1:0];
                    REG_PMASK: pmask  <= bus.wrt[NBTN-1:0];
                    REG_RMASK: rmask  <= bus.wrt[NBTN-1:0];
                    REG_CMD: begin
                        case (bus.wrt[4:0])
                            CMD_ROM_ON:   write_rom <= 1'b1;
                            CMD_BEEP_ON:  beep      <= 1'b1;
                            CMD_ROM_OFF:  write_rom <= 1'b0;
                            CMD_BEEP_OFF: beep      <= 1'b0;
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- read path ----------------
    always_comb begin
        rdata = '0;
        case (key)
            REG_NLED:  rdata = 8'(NLED);
            REG_NBTN:  rdata = 8'(NBTN);
            REG_VER:   rdata = VERSION;
            REG_LED:   rdata = 8'(ledreg);
            REG_BTN:   rdata = 8'(btns);
            REG_PPEND: rdata = 8'(ppend);
            REG_PMASK: rdata = 8'(pmask);
            REG_RMASK: rdata = 8'(rmask);
            REG_RPEND: rdata = 8'(rpend);
            default:   rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          bus.red <= '0;
        else if (bus.wen) bus.red <= bus.wrt;
        else              bus.red <= rdata;
    end

    // ---------------- outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irqa <= 1'b0;
            irqb <= 1'b0;
            leds <= '0;
        end else begin
            irqa <= |(ppend & pmask);
            irqb <= |(rpend & rmask);
            leds <= dimctl ? '0 : ledreg;
        end
    end

endmodule
